// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer in flight at a time; completion is reported as a one-cycle ACK pulse.
module apb_arbiter_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        R0_REQ,
    input  logic        R0_WRITE,
    input  logic [31:0] R0_ADDR,
    input  logic [31:0] R0_WDATA,
    input  logic [3:0]  R0_STRB,
    output logic        R0_ACK,
    output logic [31:0] R0_RDATA,
    output logic        R0_ERR,
    input  logic        R1_REQ,
    input  logic        R1_WRITE,
    input  logic [31:0] R1_ADDR,
    input  logic [31:0] R1_WDATA,
    input  logic [3:0]  R1_STRB,
    output logic        R1_ACK,
    output logic [31:0] R1_RDATA,
    output logic        R1_ERR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a requester raises Rn_REQ with its fields stable and holds them
    // until Rn_ACK; the ACK cycle itself never counts as a new request.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q;
    logic          last_q;
    logic          owner_q;
    logic [CW-1:0] cnt_q;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [31:0]   paddr_q;
    logic [31:0]   pwdata_q;
    logic [3:0]    pstrb_q;
    logic [1:0]    ack_q;
    logic [1:0]    err_q;
    logic [31:0]   rdata0_q;
    logic [31:0]   rdata1_q;

    logic          elig0;
    logic          elig1;
    logic          grant_vld;
    logic          grant_id;
    logic          sel_write;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_strb;
    logic          timeout_hit;

    assign elig0     = R0_REQ & ~ack_q[0];
    assign elig1     = R1_REQ & ~ack_q[1];
    assign grant_vld = elig0 | elig1;
    // On a tie the requester that did not win last time goes next.
    assign grant_id  = (elig0 & elig1) ? ~last_q : elig1;

    assign sel_write = grant_id ? R1_WRITE : R0_WRITE;
    assign sel_addr  = grant_id ? R1_ADDR  : R0_ADDR;
    assign sel_wdata = grant_id ? R1_WDATA : R0_WDATA;
    assign sel_strb  = grant_id ? R1_STRB  : R0_STRB;

    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            ack_q    <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            case (state_q)
                IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (grant_vld) begin
                        owner_q  <= grant_id;
                        last_q   <= grant_id;
                        pwrite_q <= sel_write;
                        paddr_q  <= sel_addr;
                        pwdata_q <= sel_write ? sel_wdata : '0;
                        pstrb_q  <= sel_write ? sel_strb : '0;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        psel_q         <= 1'b0;
                        penable_q      <= 1'b0;
                        state_q        <= IDLE;
                        ack_q[owner_q] <= 1'b1;
                        err_q[owner_q] <= PSLVERR;
                        if (owner_q) rdata1_q <= pwrite_q ? '0 : PRDATA;
                        else         rdata0_q <= pwrite_q ? '0 : PRDATA;
                    end else if (timeout_hit) begin
                        // Abandoned transfer: error status, no data.
                        psel_q         <= 1'b0;
                        penable_q      <= 1'b0;
                        state_q        <= IDLE;
                        ack_q[owner_q] <= 1'b1;
                        err_q[owner_q] <= 1'b1;
                        cnt_q          <= cnt_q + 1'b1;
                    end else if (TIMEOUT > 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;
    assign R0_ACK      = ack_q[0];
    assign R1_ACK      = ack_q[1];
    assign R0_ERR      = err_q[0];
    assign R1_ERR      = err_q[1];
    assign R0_RDATA    = rdata0_q;
    assign R1_RDATA    = rdata1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Bench for apb_arbiter_master: transfer-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_apb_arbiter_master;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  strb [2];
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rdata [2];
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_arbiter_master #(.TIMEOUT(TO)) dut (
    .PCLK(clk), .PRESET(rst),
    .R0_REQ(req[0]), .R0_WRITE(wr[0]), .R0_ADDR(addr[0]), .R0_WDATA(wdata[0]), .R0_STRB(strb[0]),
    .R0_ACK(ack[0]), .R0_RDATA(rdata[0]), .R0_ERR(err[0]),
    .R1_REQ(req[1]), .R1_WRITE(wr[1]), .R1_ADDR(addr[1]), .R1_WDATA(wdata[1]), .R1_STRB(strb[1]),
    .R1_ACK(ack[1]), .R1_RDATA(rdata[1]), .R1_ERR(err[1]),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level reference model ----------------
  typedef struct {
    bit          who;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  bit          m_valid = 0;
  bit          m_busy;
  bit          m_last;
  int          m_age;       // 0 = setup cycle, n>=1 = n-th access cycle
  xfer_t       m_cur;
  bit [1:0]    e_ack;
  bit [1:0]    e_err;
  logic [31:0] e_rdata [2];
  int          m_done = 0;
  int          m_timeouts = 0;

  task automatic model_step();
    bit [1:0]    nack;
    bit [1:0]    nerr;
    logic [31:0] nrd [2];
    bit          e0, e1;
    int          g;
    nack = '0;
    nerr = '0;
    nrd[0] = '0;
    nrd[1] = '0;
    if (rst) begin
      m_valid = 1;
      m_busy = 0;
      m_last = 1;
      m_age = 0;
      m_cur = '{who: 0, wr: 0, addr: '0, wdata: '0, strb: '0};
    end else if (!m_busy) begin
      e0 = req[0] && !e_ack[0];
      e1 = req[1] && !e_ack[1];
      if (e0 || e1) begin
        if (e0 && e1) g = m_last ? 0 : 1;
        else g = e1 ? 1 : 0;
        m_last = (g == 1);
        m_busy = 1;
        m_age = 0;
        m_cur.who = (g == 1);
        m_cur.wr = wr[g];
        m_cur.addr = addr[g];
        m_cur.wdata = wr[g] ? wdata[g] : 32'h0;
        m_cur.strb = wr[g] ? strb[g] : 4'h0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (pready) begin
      m_busy = 0;
      nack[m_cur.who] = 1;
      nerr[m_cur.who] = pslverr;
      nrd[m_cur.who] = m_cur.wr ? 32'h0 : prdata;
      m_done++;
    end else if (TO > 0 && m_age == TO) begin
      m_busy = 0;
      nack[m_cur.who] = 1;
      nerr[m_cur.who] = 1;
      m_done++;
      m_timeouts++;
    end else begin
      m_age++;
    end
    e_ack = nack;
    e_err = nerr;
    e_rdata[0] = nrd[0];
    e_rdata[1] = nrd[1];
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // One compare process: every cycle once the model has seen reset.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("psel", psel, m_busy);
      chk("penable", penable, m_busy && m_age >= 1);
      chk("pwrite", pwrite, m_cur.wr);
      chk("paddr", paddr, m_cur.addr);
      chk("pwdata", pwdata, m_cur.wdata);
      chk("pstrb", pstrb, m_cur.strb);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("r%0d_ack", n), ack[n], e_ack[n]);
        chk($sformatf("r%0d_err", n), err[n], e_err[n]);
        chk($sformatf("r%0d_rdata", n), rdata[n], e_rdata[n]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nc();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req[n] = 1'b1;
    wr[n] = w;
    addr[n] = a;
    wdata[n] = d;
    strb[n] = s;
  endtask

  task automatic do_reset();
    nc();
    rst = 1'b1;
    nc();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ack_cycles [$];
    int nth;
    int ready_pct;
    rst = 1'b1;
    req = '0;
    wr = '0;
    for (int n = 0; n < 2; n++) begin
      addr[n] = '0;
      wdata[n] = '0;
      strb[n] = '0;
    end
    prdata = '0;
    pready = 1'b0;
    pslverr = 1'b0;

    // Reset values
    nc();
    nc();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_r0_ack", ack[0], 0);
    chk("rst_r1_rdata", rdata[1], 0);
    rst = 1'b0;
    nc();

    // R0 write, zero wait states
    set_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    pready = 1'b1;
    nc();
    chk("wr_setup_psel", psel, 1);
    chk("wr_setup_penable", penable, 0);
    nc();
    chk("wr_access_penable", penable, 1);
    chk("wr_access_paddr", paddr, 32'h10);
    chk("wr_access_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_access_pstrb", pstrb, 4'hF);
    chk("wr_access_ack", ack[0], 0);
    nc();
    chk("wr_ack_k3", ack[0], 1);
    chk("wr_ack_err", err[0], 0);
    chk("wr_ack_psel", psel, 0);
    req[0] = 1'b0;
    nc();
    chk("wr_ack_single", ack[0], 0);

    // R1 read with two wait states
    set_req(1, 0, 32'h10, 32'h55AA55AA, 4'hF);
    pready = 1'b0;
    prdata = 32'hDEADBEEF;
    nc();
    nc();
    chk("rd_acc1_penable", penable, 1);
    chk("rd_acc1_pstrb", pstrb, 0);
    chk("rd_acc1_pwdata", pwdata, 0);
    nc();
    chk("rd_acc2_penable", penable, 1);
    chk("rd_acc2_paddr", paddr, 32'h10);
    nc();
    chk("rd_acc3_psel", psel, 1);
    chk("rd_acc3_ack", ack[1], 0);
    pready = 1'b1;
    nc();
    chk("rd_ack_k5", ack[1], 1);
    chk("rd_ack_rdata", rdata[1], 32'hDEADBEEF);
    chk("rd_ack_err", err[1], 0);
    req[1] = 1'b0;
    nc();

    // Read with slave error
    set_req(1, 0, 32'h20, 32'h0, 4'h0);
    pslverr = 1'b1;
    prdata = 32'h12345678;
    nc();
    nc();
    nc();
    chk("slverr_ack", ack[1], 1);
    chk("slverr_err", err[1], 1);
    chk("slverr_rdata", rdata[1], 32'h12345678);
    req[1] = 1'b0;
    pslverr = 1'b0;
    nc();

    // Timeout with PREADY stuck low
    set_req(0, 0, 32'h30, 32'h0, 4'h0);
    pready = 1'b0;
    prdata = 32'hCAFEF00D;
    nc();
    chk("to_setup_penable", penable, 0);
    for (int i = 0; i < TO; i++) begin
      nc();
      chk("to_access_penable", penable, 1);
      chk("to_access_ack", ack[0], 0);
    end
    nc();
    chk("to_ack", ack[0], 1);
    chk("to_err", err[0], 1);
    chk("to_rdata", rdata[0], 0);
    chk("to_psel", psel, 0);
    req[0] = 1'b0;
    pready = 1'b1;
    nc();

    // Round-robin with both requests held after reset
    do_reset();
    set_req(0, 1, 32'hA0, 32'h0000AAAA, 4'h3);
    set_req(1, 0, 32'hB0, 32'h0, 4'h0);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    nth = 0;
    for (int c = 1; c <= 14; c++) begin
      nc();
      if (ack[0] || ack[1]) begin
        chk("rr_one_ack", ack[0] & ack[1], 0);
        if (exp_q.size() > 0) begin
          chk("rr_order", {31'h0, ack[1]}, exp_q.pop_front());
          nth++;
          chk("rr_ack_cycle", c, 3 * nth);
        end
        if (exp_q.size() == 0) req = '0;
      end
    end
    chk("rr_all_granted", exp_q.size(), 0);
    req = '0;
    nc();

    // Reset during ACCESS aborts; held request is re-arbitrated
    set_req(0, 1, 32'h40, 32'h11112222, 4'h3);
    pready = 1'b0;
    nc();
    nc();
    chk("abort_in_access", penable, 1);
    rst = 1'b1;
    nc();
    chk("abort_psel", psel, 0);
    chk("abort_penable", penable, 0);
    chk("abort_paddr", paddr, 0);
    chk("abort_pwdata", pwdata, 0);
    chk("abort_pstrb", pstrb, 0);
    chk("abort_pwrite", pwrite, 0);
    chk("abort_no_ack", ack[0], 0);
    rst = 1'b0;
    nc();
    chk("abort_resetup_psel", psel, 1);
    chk("abort_resetup_penable", penable, 0);
    chk("abort_resetup_paddr", paddr, 32'h40);
    pready = 1'b1;
    nc();
    nc();
    chk("abort_final_ack", ack[0], 1);
    req[0] = 1'b0;
    nc();

    // Randomized traffic
    ready_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: ready_pct = 0;
          1: ready_pct = 25;
          2: ready_pct = 60;
          default: ready_pct = 100;
        endcase
      end
      for (int n = 0; n < 2; n++) begin
        if (req[n] && ack[n]) begin
          if ($urandom_range(0, 1) == 0) req[n] = 1'b0;
          else set_req(n, $urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
        end else if (!req[n] && $urandom_range(0, 3) == 0) begin
          set_req(n, $urandom_range(0, 1), $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
      end
      pready = ($urandom_range(1, 100) <= ready_pct);
      prdata = $urandom;
      pslverr = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 399) == 0);
      nc();
    end
    rst = 1'b0;
    req = '0;
    nc();
    chk("rand_transfers_seen", m_done > 100, 1);
    chk("rand_timeouts_seen", m_timeouts > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
